// File: rtl/attention_ctrl_pkg.sv
// rtl/attention_ctrl_pkg.sv - shared types and constants for the attention sequencers
package attention_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADD,
    RESULT,
    DONE
  } seq_state_t;

  localparam logic MODE_FRAC  = 1'b0;
  localparam logic MODE_VALUE = 1'b1;

  localparam int DEFAULT_MUL_LAT = 2;

endpackage

// File: rtl/latency_timer.sv
// rtl/latency_timer.sv - loadable down-counter with a zero flag
module latency_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         _reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Saturates at zero so a stray dec can never wrap into a long wait.
  always_ff @(posedge clk) begin
    if (_reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/adder_sequencer.sv
// rtl/adder_sequencer.sv - tile sequencer for the multiplier array and 16-lane adder stage
module adder_sequencer
  import attention_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEFAULT_MUL_LAT,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             _reset,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] tile_count,
  output logic             busy,
  output logic             mul_start,
  output logic [CNT_W-1:0] tile_idx,
  output logic             adder_enable,
  output logic             MulFractionsFlag,
  output logic             MulValueFlag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             done
);

  localparam int TMR_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int TMR_LOAD = (MUL_LAT > 0) ? (MUL_LAT - 1) : 0;

  seq_state_t       state, state_n;
  logic             mode_q;
  logic [CNT_W-1:0] count_q;
  logic             last_tile;
  logic             accept;
  logic             tmr_load, tmr_dec, tmr_zero;

  latency_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    ._reset     (_reset),
    .load       (tmr_load),
    .load_value (TMR_W'(TMR_LOAD)),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  // count_q is at least 1 whenever RESULT is reachable, so the subtraction cannot wrap.
  assign last_tile = (tile_idx == (count_q - CNT_W'(1)));
  assign accept    = (state == RESULT) && res_ready;

  always_ff @(posedge clk) begin
    if (_reset) begin
      state    <= IDLE;
      mode_q   <= MODE_FRAC;
      count_q  <= '0;
      tile_idx <= '0;
    end else begin
      state <= state_n;
      if ((state == IDLE) && start) begin
        mode_q   <= mode;
        count_q  <= tile_count;
        tile_idx <= '0;
      end else if (accept && !last_tile) begin
        tile_idx <= tile_idx + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n      = state;
    mul_start    = 1'b0;
    adder_enable = 1'b0;
    res_valid    = 1'b0;
    done         = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (tile_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        if (MUL_LAT == 0) begin
          state_n = ADD;
        end else begin
          tmr_load = 1'b1;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (tmr_zero) begin
          state_n = ADD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ADD: begin
        adder_enable = 1'b1;
        state_n      = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_n = last_tile ? DONE : ISSUE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Flags come from the latched mode, so they cannot move mid-job.
  assign busy             = (state != IDLE);
  assign MulFractionsFlag = busy && (mode_q == MODE_FRAC);
  assign MulValueFlag     = busy && (mode_q == MODE_VALUE);

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Control FSM that sequences the 16-lane fraction/value adder stage of the self-attention datapath. It accepts a job (Q·Kᵀ score accumulation or attention-prob·V accumulation) of N tiles. For each tile it launches the multiplier array, waits the multiplier latency, and pulses the adder enable with the correct mode flag. It then holds a result-valid handshake toward the downstream buffer. The block sits between the top-level attention controller and the multiplier/adder pair.

## Interface
Parameters:
- MUL_LAT, 2, multiplier array latency in cycles from mul_start to stable products (0 allowed).
- CNT_W, 8, width of tile counters.

Ports:
- clk  in  1  rising-edge clock.
- _reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- mode  in  1  0 = fraction (Q·K) mode, 1 = value (prob·V) mode; latched on start.
- tile_count  in  CNT_W  tiles in job; latched on start.
- busy  out  1  high from the cycle after start is accepted until the cycle after DONE.
- mul_start  out  1  one-cycle launch pulse to the multiplier array.
- tile_idx  out  CNT_W  tile being processed; valid whenever busy.
- adder_enable  out  1  enable to adder stage; one-cycle pulse per tile.
- MulFractionsFlag  out  1  equals latched mode==0 while busy, else 0.
- MulValueFlag  out  1  equals latched mode==1 while busy, else 0.
- res_valid  out  1  adder outputs hold the result of tile_idx.
- res_ready  in  1  downstream accepts the result.
- done  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, ISSUE, WAIT, ADD, RESULT, DONE.
- IDLE: if start, latch mode, tile_count, and tile_idx←0.
  - If tile_count==0 → DONE, with no mul_start or adder_enable issued.
  - Else → ISSUE.
- ISSUE: mul_start=1.
  - If MUL_LAT==0 → ADD.
  - Else load wait counter with MUL_LAT-1 → WAIT.
- WAIT: decrement counter; at 0 → ADD.
- ADD: adder_enable=1 for exactly one cycle → RESULT. The adder registers at the end of this cycle.
- RESULT: res_valid=1, held until res_ready.
  - On res_valid&res_ready, if tile_idx==tile_count-1 → DONE.
  - Otherwise tile_idx+1 → ISSUE.
- DONE: done=1 for one cycle → IDLE.
- start is ignored whenever state≠IDLE. A start in the DONE cycle is dropped.
- Only one mode flag is ever high, and both flags stay stable during adder_enable.
- tile_idx is an unsigned wrap-free counter. tile_count=2^CNT_W-1 is the maximum job size.

## Timing
- Reset (_reset=1 at a clock edge): state←IDLE. busy, mul_start, adder_enable, res_valid, done, both flags ←0. tile_idx←0. Reset applies mid-job with no further pulses.
- The start cycle is T. ISSUE is T+1, ADD is T+2+MUL_LAT, and the first res_valid is at T+3+MUL_LAT.
- With res_ready tied high, each tile takes MUL_LAT+3 cycles. A job takes 1+N·(MUL_LAT+3)+1 cycles from start to the done cycle inclusive.
- Backpressure: each cycle with res_ready=0 in RESULT adds one cycle. The adder is not re-enabled while res_valid is high, so results stay stable.
- busy deasserts in the cycle after done.

## Structure
- Shared package attention_ctrl_pkg holds:
  - the state enum (IDLE..DONE);
  - MODE_FRAC=1'b0 and MODE_VALUE=1'b1;
  - default MUL_LAT.
- One natural sub-module is latency_timer: a loadable down-counter with a zero flag, reused by other sequencers. Everything else is a single FSM module.

## Test plan
- Reset mid-job: assert _reset during WAIT of tile 2 → next cycle all outputs 0, state IDLE. A later start works normally.
- Fraction job: mode=0, tile_count=4, MUL_LAT=2, res_ready=1. Requires:
  - mul_start at T+1, T+6, T+11, T+16;
  - adder_enable at T+4, T+9, T+14, T+19, with MulFractionsFlag=1 and MulValueFlag=0;
  - done at T+21.
- Value job with backpressure: mode=1, tile_count=2, res_ready low for 3 cycles on tile 0 → res_valid held 4 cycles with tile_idx=0. No second adder_enable occurs until the handshake, and done is 3 cycles later than the unstalled case.
- Zero tiles: tile_count=0 → done at T+1, with no mul_start and no adder_enable.
- MUL_LAT=0 and start while busy: ADD directly follows ISSUE, and the per-tile period is 3 cycles. A start pulsed in RESULT or DONE is ignored, and tile_count is not re-latched.
